// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory load/store port between the CPU LSU and the debug peripheral
module memory_port_arbiter #(
  parameter int XLEN = 32,
  parameter int BURST_LIMIT = 4,
  parameter int CNT_WIDTH = 3,
  parameter int LS_SEL_WIDTH = 1,
  parameter int MEMORY_STATE_WIDTH = 2,
  parameter logic [MEMORY_STATE_WIDTH:0] MEM_IDLE = 0,
  parameter logic [MEMORY_STATE_WIDTH:0] READ_AWAITING = 1,
  parameter logic [MEMORY_STATE_WIDTH:0] READ_SUCCESS = 3,
  parameter logic [MEMORY_STATE_WIDTH:0] WRITE_SUCCESS = 4,
  parameter logic [LS_SEL_WIDTH:0] LS_TYPE_NONE = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Halt_Cpu,
  input  logic                          i_Cpu_LS_Enable,
  input  logic [LS_SEL_WIDTH:0]         i_Cpu_LS_Type,
  input  logic                          i_Cpu_LS_Write_Enable,
  input  logic [XLEN-1:0]               i_Cpu_LS_Address,
  input  logic [XLEN-1:0]               i_Cpu_LS_Data,
  input  logic                          i_Dbg_LS_Enable,
  input  logic [LS_SEL_WIDTH:0]         i_Dbg_LS_Type,
  input  logic                          i_Dbg_LS_Write_Enable,
  input  logic [XLEN-1:0]               i_Dbg_LS_Address,
  input  logic [XLEN-1:0]               i_Dbg_LS_Data,
  output logic                          o_Cpu_Grant,
  output logic                          o_Dbg_Grant,
  output logic [MEMORY_STATE_WIDTH:0]   o_Cpu_Memory_State,
  output logic [MEMORY_STATE_WIDTH:0]   o_Dbg_Memory_State,
  output logic                          o_Memory_LS_Enable,
  output logic [LS_SEL_WIDTH:0]         o_Memory_LS_Type,
  output logic                          o_Memory_LS_Write_Enable,
  output logic [XLEN-1:0]               o_Memory_LS_Address,
  output logic [XLEN-1:0]               o_Memory_LS_Data,
  input  logic [MEMORY_STATE_WIDTH:0]   i_Memory_State
);
  typedef enum logic [1:0] {s_IDLE, s_CPU, s_DBG, s_DRAIN} state_t;
  state_t state, state_nx;
  logic last_dbg, last_dbg_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx, cnt_inc;
  logic mem_idle, done, any, other, own_en, sel;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= s_IDLE;
      last_dbg <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      last_dbg <= last_dbg_nx;
      cnt <= cnt_nx;
    end
  end
  // After a drain the requester that did not own last goes first; from idle, halt or round-robin breaks ties.
  always_comb begin
    mem_idle = i_Memory_State == MEM_IDLE;
    done = i_Memory_State == READ_SUCCESS || i_Memory_State == WRITE_SUCCESS;
    any = i_Cpu_LS_Enable | i_Dbg_LS_Enable;
    other = state == s_CPU ? i_Dbg_LS_Enable : i_Cpu_LS_Enable;
    own_en = state == s_CPU ? i_Cpu_LS_Enable : i_Dbg_LS_Enable;
    cnt_inc = cnt + 1'b1;
    sel = state == s_DRAIN ? (last_dbg ? i_Dbg_LS_Enable & ~i_Cpu_LS_Enable : i_Dbg_LS_Enable)
                           : i_Dbg_LS_Enable & (~i_Cpu_LS_Enable | i_Halt_Cpu | ~last_dbg);
    state_nx = state;
    last_dbg_nx = last_dbg;
    cnt_nx = '0;
    if (state == s_IDLE || state == s_DRAIN) begin
      if (mem_idle) begin
        state_nx = !any ? s_IDLE : sel ? s_DBG : s_CPU;
        last_dbg_nx = any ? sel : last_dbg;
      end
    end else begin
      cnt_nx = !other ? '0 : done ? cnt_inc : cnt;
      if (!own_en || (done && other && (cnt_inc == CNT_WIDTH'(BURST_LIMIT) || (state == s_CPU && i_Halt_Cpu)))) begin
        state_nx = s_DRAIN;
        cnt_nx = '0;
      end
    end
  end
  always_comb begin
    o_Cpu_Grant = state == s_CPU;
    o_Dbg_Grant = state == s_DBG;
    o_Cpu_Memory_State = o_Cpu_Grant ? i_Memory_State : READ_AWAITING;
    o_Dbg_Memory_State = o_Dbg_Grant ? i_Memory_State : READ_AWAITING;
    o_Memory_LS_Enable = o_Cpu_Grant ? i_Cpu_LS_Enable : o_Dbg_Grant ? i_Dbg_LS_Enable : 1'b0;
    o_Memory_LS_Type = o_Cpu_Grant ? i_Cpu_LS_Type : o_Dbg_Grant ? i_Dbg_LS_Type : LS_TYPE_NONE;
    o_Memory_LS_Write_Enable = o_Cpu_Grant ? i_Cpu_LS_Write_Enable : o_Dbg_Grant ? i_Dbg_LS_Write_Enable : 1'b0;
    o_Memory_LS_Address = o_Cpu_Grant ? i_Cpu_LS_Address : o_Dbg_Grant ? i_Dbg_LS_Address : '0;
    o_Memory_LS_Data = o_Cpu_Grant ? i_Cpu_LS_Data : o_Dbg_Grant ? i_Dbg_LS_Data : '0;
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed scenarios for the CPU/debug memory port arbiter
module tb_memory_port_arbiter;
  localparam logic [2:0] M_IDLE = 0, M_RA = 1, M_RS = 3, M_WS = 4;
  logic i_Clock = 0, i_Reset = 0, i_Halt_Cpu = 0;
  logic i_Cpu_LS_Enable = 0, i_Cpu_LS_Write_Enable = 0, i_Dbg_LS_Enable = 0, i_Dbg_LS_Write_Enable = 0;
  logic [1:0] i_Cpu_LS_Type = 0, i_Dbg_LS_Type = 0;
  logic [31:0] i_Cpu_LS_Address = 0, i_Cpu_LS_Data = 0, i_Dbg_LS_Address = 0, i_Dbg_LS_Data = 0;
  logic [2:0] i_Memory_State = M_IDLE;
  logic o_Cpu_Grant, o_Dbg_Grant, o_Memory_LS_Enable, o_Memory_LS_Write_Enable;
  logic [2:0] o_Cpu_Memory_State, o_Dbg_Memory_State;
  logic [1:0] o_Memory_LS_Type;
  logic [31:0] o_Memory_LS_Address, o_Memory_LS_Data;
  int n = 0, f = 0;
  memory_port_arbiter dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Halt_Cpu(i_Halt_Cpu),
    .i_Cpu_LS_Enable(i_Cpu_LS_Enable), .i_Cpu_LS_Type(i_Cpu_LS_Type),
    .i_Cpu_LS_Write_Enable(i_Cpu_LS_Write_Enable), .i_Cpu_LS_Address(i_Cpu_LS_Address),
    .i_Cpu_LS_Data(i_Cpu_LS_Data),
    .i_Dbg_LS_Enable(i_Dbg_LS_Enable), .i_Dbg_LS_Type(i_Dbg_LS_Type),
    .i_Dbg_LS_Write_Enable(i_Dbg_LS_Write_Enable), .i_Dbg_LS_Address(i_Dbg_LS_Address),
    .i_Dbg_LS_Data(i_Dbg_LS_Data),
    .o_Cpu_Grant(o_Cpu_Grant), .o_Dbg_Grant(o_Dbg_Grant),
    .o_Cpu_Memory_State(o_Cpu_Memory_State), .o_Dbg_Memory_State(o_Dbg_Memory_State),
    .o_Memory_LS_Enable(o_Memory_LS_Enable), .o_Memory_LS_Type(o_Memory_LS_Type),
    .o_Memory_LS_Write_Enable(o_Memory_LS_Write_Enable), .o_Memory_LS_Address(o_Memory_LS_Address),
    .o_Memory_LS_Data(o_Memory_LS_Data), .i_Memory_State(i_Memory_State)
  );
  always #5 i_Clock = ~i_Clock;
  always @(negedge i_Clock) assert (!(o_Cpu_Grant && o_Dbg_Grant)) else $error("FAIL both_grants high");
  task automatic tick;
    @(posedge i_Clock);
    #1;
  endtask
  task automatic test_reset;
    i_Reset = 1; tick; i_Reset = 0;
    n++; if (o_Cpu_Grant !== 1'b0) begin f++; $display("FAIL rst_cpu_grant got %0h want 0", o_Cpu_Grant); end
    n++; if (o_Dbg_Grant !== 1'b0) begin f++; $display("FAIL rst_dbg_grant got %0h want 0", o_Dbg_Grant); end
    n++; if (o_Memory_LS_Type !== 2'd0 || o_Memory_LS_Enable !== 1'b0) begin f++; $display("FAIL rst_bundle type %0h en %0h want 0 0", o_Memory_LS_Type, o_Memory_LS_Enable); end
    n++; if (o_Cpu_Memory_State !== M_RA || o_Dbg_Memory_State !== M_RA) begin f++; $display("FAIL rst_req_states %0h %0h want 1 1", o_Cpu_Memory_State, o_Dbg_Memory_State); end
  endtask
  task automatic test_cpu_only;
    i_Cpu_LS_Enable = 1; i_Cpu_LS_Address = 32'h80; i_Cpu_LS_Data = 32'hCAFE_0001;
    i_Cpu_LS_Type = 2'd2; i_Cpu_LS_Write_Enable = 1; #1;
    n++; if (o_Cpu_Grant !== 1'b0) begin f++; $display("FAIL cpu_grant_early got %0h want 0", o_Cpu_Grant); end
    tick;
    n++; if (o_Cpu_Grant !== 1'b1) begin f++; $display("FAIL cpu_grant got %0h want 1", o_Cpu_Grant); end
    n++; if (o_Memory_LS_Address !== 32'h80) begin f++; $display("FAIL cpu_addr got %0h want 80", o_Memory_LS_Address); end
    n++; if (o_Memory_LS_Data !== 32'hCAFE_0001 || o_Memory_LS_Write_Enable !== 1'b1) begin f++; $display("FAIL cpu_data got %0h we %0h want cafe0001 1", o_Memory_LS_Data, o_Memory_LS_Write_Enable); end
    n++; if (o_Memory_LS_Type !== 2'd2 || o_Memory_LS_Enable !== 1'b1) begin f++; $display("FAIL cpu_type got %0h en %0h want 2 1", o_Memory_LS_Type, o_Memory_LS_Enable); end
    i_Memory_State = M_WS; #1;
    n++; if (o_Cpu_Memory_State !== M_WS || o_Dbg_Memory_State !== M_RA) begin f++; $display("FAIL cpu_state_fwd got %0h %0h want 4 1", o_Cpu_Memory_State, o_Dbg_Memory_State); end
    i_Cpu_LS_Enable = 0; i_Cpu_LS_Write_Enable = 0; i_Memory_State = M_IDLE; tick;
    n++; if (o_Cpu_Grant !== 1'b0 || o_Memory_LS_Address !== 32'h0) begin f++; $display("FAIL cpu_drain grant %0h addr %0h want 0 0", o_Cpu_Grant, o_Memory_LS_Address); end
    tick;
  endtask
  task automatic test_round_robin;
    i_Cpu_LS_Enable = 1; i_Dbg_LS_Enable = 1; i_Dbg_LS_Address = 32'h40; tick;
    n++; if (o_Dbg_Grant !== 1'b1 || o_Cpu_Grant !== 1'b0) begin f++; $display("FAIL rr_first got cpu %0h dbg %0h want 0 1", o_Cpu_Grant, o_Dbg_Grant); end
    n++; if (o_Memory_LS_Address !== 32'h40) begin f++; $display("FAIL rr_dbg_addr got %0h want 40", o_Memory_LS_Address); end
    i_Dbg_LS_Enable = 0; tick;
    n++; if (o_Dbg_Grant !== 1'b0 || o_Cpu_Grant !== 1'b0) begin f++; $display("FAIL rr_drain got cpu %0h dbg %0h want 0 0", o_Cpu_Grant, o_Dbg_Grant); end
    i_Dbg_LS_Enable = 1; tick;
    n++; if (o_Cpu_Grant !== 1'b1 || o_Memory_LS_Address !== 32'h80) begin f++; $display("FAIL rr_second got cpu %0h addr %0h want 1 80", o_Cpu_Grant, o_Memory_LS_Address); end
    i_Cpu_LS_Enable = 0; i_Dbg_LS_Enable = 0; tick; tick;
  endtask
  task automatic test_burst;
    i_Cpu_LS_Enable = 1; tick;
    i_Dbg_LS_Enable = 1;
    for (int i = 1; i <= 4; i++) begin
      i_Memory_State = M_RA; tick;
      n++; if (o_Cpu_Grant !== 1'b1) begin f++; $display("FAIL burst_hold_%0d got %0h want 1", i, o_Cpu_Grant); end
      i_Memory_State = M_RS; tick;
      n++; if (o_Cpu_Grant !== (i < 4)) begin f++; $display("FAIL burst_after_%0d got %0h want %0h", i, o_Cpu_Grant, i < 4); end
    end
    i_Memory_State = M_RA; tick;
    n++; if (o_Cpu_Grant !== 1'b0 || o_Dbg_Grant !== 1'b0) begin f++; $display("FAIL burst_drain_busy got cpu %0h dbg %0h want 0 0", o_Cpu_Grant, o_Dbg_Grant); end
    i_Memory_State = M_IDLE; tick;
    n++; if (o_Dbg_Grant !== 1'b1) begin f++; $display("FAIL burst_handover got %0h want 1", o_Dbg_Grant); end
    i_Cpu_LS_Enable = 0; i_Dbg_LS_Enable = 0; tick; tick;
  endtask
  task automatic test_halt;
    i_Cpu_LS_Enable = 1; tick;
    i_Dbg_LS_Enable = 1; i_Halt_Cpu = 1; i_Memory_State = M_RA; tick;
    n++; if (o_Cpu_Grant !== 1'b1) begin f++; $display("FAIL halt_hold got %0h want 1", o_Cpu_Grant); end
    i_Memory_State = M_RS; tick;
    n++; if (o_Cpu_Grant !== 1'b0 || o_Cpu_Memory_State !== M_RA) begin f++; $display("FAIL halt_preempt grant %0h state %0h want 0 1", o_Cpu_Grant, o_Cpu_Memory_State); end
    i_Memory_State = M_IDLE; tick;
    n++; if (o_Dbg_Grant !== 1'b1 || o_Dbg_Memory_State !== M_IDLE) begin f++; $display("FAIL halt_dbg grant %0h state %0h want 1 0", o_Dbg_Grant, o_Dbg_Memory_State); end
    n++; if (o_Cpu_Memory_State !== M_RA) begin f++; $display("FAIL halt_cpu_state got %0h want 1", o_Cpu_Memory_State); end
    i_Halt_Cpu = 0; i_Cpu_LS_Enable = 0;
  endtask
  task automatic test_reset_mid;
    i_Memory_State = M_RA; tick;
    i_Reset = 1; tick; i_Reset = 0; i_Dbg_LS_Enable = 0; i_Memory_State = M_IDLE;
    n++; if (o_Dbg_Grant !== 1'b0 || o_Cpu_Grant !== 1'b0) begin f++; $display("FAIL rstmid_grants cpu %0h dbg %0h want 0 0", o_Cpu_Grant, o_Dbg_Grant); end
    n++; if (o_Memory_LS_Type !== 2'd0 || o_Memory_LS_Address !== 32'h0) begin f++; $display("FAIL rstmid_bundle type %0h addr %0h want 0 0", o_Memory_LS_Type, o_Memory_LS_Address); end
    i_Cpu_LS_Enable = 1; i_Dbg_LS_Enable = 1; tick;
    n++; if (o_Dbg_Grant !== 1'b1) begin f++; $display("FAIL rstmid_last_owner got %0h want 1", o_Dbg_Grant); end
    i_Cpu_LS_Enable = 0; i_Dbg_LS_Enable = 0; tick; tick;
  endtask
  task automatic test_drop_busy;
    i_Cpu_LS_Enable = 1; tick;
    i_Memory_State = M_RA; i_Cpu_LS_Enable = 0; i_Dbg_LS_Enable = 1; tick;
    for (int i = 0; i < 3; i++) begin
      n++; if (o_Cpu_Grant !== 1'b0 || o_Dbg_Grant !== 1'b0) begin f++; $display("FAIL dropbusy_%0d cpu %0h dbg %0h want 0 0", i, o_Cpu_Grant, o_Dbg_Grant); end
      tick;
    end
    i_Memory_State = M_IDLE; tick;
    n++; if (o_Dbg_Grant !== 1'b1) begin f++; $display("FAIL dropbusy_grant got %0h want 1", o_Dbg_Grant); end
    i_Dbg_LS_Enable = 0; tick; tick;
    i_Cpu_LS_Enable = 1; i_Dbg_LS_Enable = 1; tick;
    n++; if (o_Cpu_Grant !== 1'b1) begin f++; $display("FAIL idle_rr_cpu got %0h want 1", o_Cpu_Grant); end
  endtask
  task automatic test_drop_with_completion;
    i_Memory_State = M_RS; i_Cpu_LS_Enable = 0; tick;
    n++; if (o_Cpu_Grant !== 1'b0 || o_Memory_LS_Enable !== 1'b0) begin f++; $display("FAIL dropdone grant %0h en %0h want 0 0", o_Cpu_Grant, o_Memory_LS_Enable); end
    i_Memory_State = M_IDLE; tick;
    n++; if (o_Dbg_Grant !== 1'b1) begin f++; $display("FAIL dropdone_next got %0h want 1", o_Dbg_Grant); end
    i_Dbg_LS_Enable = 0; tick; tick;
  endtask
  initial begin
    test_reset;
    test_cpu_only;
    test_round_robin;
    test_burst;
    test_halt;
    test_reset_mid;
    test_drop_busy;
    test_drop_with_completion;
    $display("== %0d vectors applied, %0d miscompares ==", n, f);
    $finish;
  end
endmodule
